// File: rtl/id_hazard_branch_unit.sv
// id_hazard_branch_unit
//   Decode-side partner of the fetch stage. Holds the IF/ID register, detects
//   load-use hazards against EX, and resolves BEQ/BNE/J in decode with a
//   single-bubble penalty.
//
// Ports
//   clk, reset            : single clock, synchronous active-low reset
//   inputIR, inputPC      : instruction / PC from fetch
//   rs_data, rt_data      : register-file read data for rs_addr / rt_addr
//   ex_isLoad, ex_destReg : EX-stage LW flag and destination register
//   IR_ID, PC_ID          : IF/ID register contents
//   rs_addr, rt_addr      : register-file read addresses (IR_ID fields)
//   id_valid              : IF/ID instruction may advance to ID/EX
//   is_Branch_Taken       : redirect fetch to branchPC
//   branchPC              : redirect target (0 when not taken)
//   isDataInterLock       : freeze fetch
//   stall_count, flush_count : saturating perf counters (ID_PERF_CNT_EN only)
//
// Build option
//   ID_PERF_CNT_EN : adds the stall/flush performance counters and their ports.
module id_hazard_branch_unit #(
  parameter logic [31:0] NOP_IR    = 32'h0000_0000,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          inputIR,
  input  logic [31:0]          inputPC,
  input  logic [31:0]          rs_data,
  input  logic [31:0]          rt_data,
  input  logic                 ex_isLoad,
  input  logic [4:0]           ex_destReg,
  output logic [31:0]          IR_ID,
  output logic [31:0]          PC_ID,
  output logic [4:0]           rs_addr,
  output logic [4:0]           rt_addr,
  output logic                 id_valid,
  output logic                 is_Branch_Taken,
  output logic [31:0]          branchPC,
  output logic                 isDataInterLock
`ifdef ID_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_e;

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  logic [5:0]  opcode;
  logic        is_beq, is_bne, is_j, uses_rt;
  logic        hazard, take;
  logic [31:0] pc_plus4, br_target, j_target;

  // ---------------- decode ----------------
  assign opcode  = ir_q[31:26];
  assign rs_addr = ir_q[25:21];
  assign rt_addr = ir_q[20:16];
  assign is_beq  = (opcode == OP_BEQ);
  assign is_bne  = (opcode == OP_BNE);
  assign is_j    = (opcode == OP_J);
  assign uses_rt = (opcode == OP_RTYPE) | is_beq | is_bne | (opcode == OP_SW);

  // J names no registers, so it can never interlock. Everything else reads rs.
  assign hazard = valid_q & ex_isLoad & (ex_destReg != 5'd0) & ~is_j &
                  ((ex_destReg == rs_addr) | (uses_rt & (ex_destReg == rt_addr)));

  // Hazard wins: a branch on a loading operand waits for the interlock to clear.
  assign take = valid_q & ~hazard &
                ((is_beq & (rs_data == rt_data)) |
                 (is_bne & (rs_data != rt_data)) |
                 is_j);

  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], ir_q[25:0], 2'b00};

  assign IR_ID           = ir_q;
  assign PC_ID           = pc_q;
  assign id_valid        = valid_q & ~hazard;
  assign isDataInterLock = hazard;
  assign is_Branch_Taken = take;
  assign branchPC        = take ? (is_j ? j_target : br_target) : 32'd0;

  // ---------------- IF/ID control FSM ----------------
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    case (state_q)
      RUN, STALL: begin
        if (hazard) begin
          state_d = STALL;              // hold IF/ID
        end else if (take) begin
          ir_d    = NOP_IR;             // squash the wrong-path slot
          valid_d = 1'b0;
          state_d = FLUSH;
        end else begin
          ir_d    = inputIR;
          pc_d    = inputPC;
          valid_d = 1'b1;
          state_d = RUN;
        end
      end
      FLUSH: begin
        // fetch now presents the redirect target
        ir_d    = inputIR;
        pc_d    = inputPC;
        valid_d = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      ir_q    <= NOP_IR;
      pc_q    <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

`ifdef ID_PERF_CNT_EN
  // ---------------- saturating performance counters ----------------
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (hazard && !(&stall_q)) stall_q <= stall_q + CNT_ONE;
      if (take   && !(&flush_q)) flush_q <= flush_q + CNT_ONE;
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;
`else
  // Counter width only matters when the counters are built.
  logic unused_cnt_cfg;
  assign unused_cnt_cfg = (CNT_WIDTH > 0);
`endif

endmodule

// File: tb/tb_id_hazard_branch_unit.sv
// Directed self-checking bench for id_hazard_branch_unit.
module tb_id_hazard_branch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inputIR, inputPC, rs_data, rt_data;
  logic        ex_isLoad;
  logic [4:0]  ex_destReg;
  logic [31:0] IR_ID, PC_ID, branchPC;
  logic [4:0]  rs_addr, rt_addr;
  logic        id_valid, is_Branch_Taken, isDataInterLock;
`ifdef ID_PERF_CNT_EN
  logic [3:0]  stall_count, flush_count;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  id_hazard_branch_unit #(.NOP_IR(32'h0000_0000), .CNT_WIDTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .inputIR         (inputIR),
    .inputPC         (inputPC),
    .rs_data         (rs_data),
    .rt_data         (rt_data),
    .ex_isLoad       (ex_isLoad),
    .ex_destReg      (ex_destReg),
    .IR_ID           (IR_ID),
    .PC_ID           (PC_ID),
    .rs_addr         (rs_addr),
    .rt_addr         (rt_addr),
    .id_valid        (id_valid),
    .is_Branch_Taken (is_Branch_Taken),
    .branchPC        (branchPC),
    .isDataInterLock (isDataInterLock)
`ifdef ID_PERF_CNT_EN
    ,
    .stall_count     (stall_count),
    .flush_count     (flush_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // advance one clock, then settle past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; inputIR = 32'h8C22_0004; inputPC = 32'h44;
    rs_data = 32'd0; rt_data = 32'd0; ex_isLoad = 1'b0; ex_destReg = 5'd0;

    // ---- reset ----
    tick(); tick();
    chk("rst_ir",    IR_ID, 32'h0);
    chk("rst_pc",    PC_ID, 32'h0);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_take",  {31'd0, is_Branch_Taken}, 32'd0);
    chk("rst_bpc",   branchPC, 32'h0);
    chk("rst_ilk",   {31'd0, isDataInterLock}, 32'd0);

    // ---- load-use ----
    reset = 1'b1; inputIR = 32'h0022_1820; inputPC = 32'h100;
    tick();
    chk("lu_ir",    IR_ID, 32'h0022_1820);
    chk("lu_rs",    {27'd0, rs_addr}, 32'd1);
    chk("lu_rt",    {27'd0, rt_addr}, 32'd2);
    ex_isLoad = 1'b1; ex_destReg = 5'd1; #1;
    chk("lu_ilk",   {31'd0, isDataInterLock}, 32'd1);
    chk("lu_valid", {31'd0, id_valid}, 32'd0);
    inputIR = 32'h8C22_0004; inputPC = 32'h108;
    tick();
    chk("lu_hold_ir", IR_ID, 32'h0022_1820);
    chk("lu_hold_pc", PC_ID, 32'h100);
    ex_isLoad = 1'b0; #1;
    chk("lu_clr_ilk",   {31'd0, isDataInterLock}, 32'd0);
    chk("lu_clr_valid", {31'd0, id_valid}, 32'd1);
    ex_isLoad = 1'b1; ex_destReg = 5'd0; #1;
    chk("lu_r0", {31'd0, isDataInterLock}, 32'd0);
    ex_destReg = 5'd2; #1;
    chk("lu_rt_match", {31'd0, isDataInterLock}, 32'd1);
    ex_destReg = 5'd3; #1;
    chk("lu_nomatch", {31'd0, isDataInterLock}, 32'd0);
    ex_isLoad = 1'b0;
    tick();
    chk("lw_ir", IR_ID, 32'h8C22_0004);
    ex_isLoad = 1'b1; ex_destReg = 5'd2; #1;
    chk("lw_rt_ignored", {31'd0, isDataInterLock}, 32'd0);
    ex_destReg = 5'd1; #1;
    chk("lw_rs_ilk", {31'd0, isDataInterLock}, 32'd1);
    ex_isLoad = 1'b0;

    // ---- BEQ ----
    inputIR = 32'h1022_0003; inputPC = 32'h10;
    tick();
    rs_data = 32'd5; rt_data = 32'd6; #1;
    chk("beq_ne_take", {31'd0, is_Branch_Taken}, 32'd0);
    chk("beq_ne_bpc",  branchPC, 32'h0);
    rt_data = 32'd5; #1;
    chk("beq_take",  {31'd0, is_Branch_Taken}, 32'd1);
    chk("beq_bpc",   branchPC, 32'h20);
    chk("beq_valid", {31'd0, id_valid}, 32'd1);
    inputIR = 32'hDEAD_BEEF; inputPC = 32'h14;
    tick();
    chk("flush_ir",    IR_ID, 32'h0);
    chk("flush_valid", {31'd0, id_valid}, 32'd0);
    chk("flush_take",  {31'd0, is_Branch_Taken}, 32'd0);
    inputIR = 32'h0022_1820; inputPC = 32'h20;
    tick();
    chk("tgt_pc",    PC_ID, 32'h20);
    chk("tgt_ir",    IR_ID, 32'h0022_1820);
    chk("tgt_valid", {31'd0, id_valid}, 32'd1);

    // ---- BNE / J ----
    inputIR = 32'h1422_FFFF; inputPC = 32'h30;
    tick();
    chk("bne_eq_take", {31'd0, is_Branch_Taken}, 32'd0);
    rt_data = 32'd6; #1;
    chk("bne_take", {31'd0, is_Branch_Taken}, 32'd1);
    chk("bne_bpc",  branchPC, 32'h30);
    tick();
    inputIR = 32'h0800_0040; inputPC = 32'h1000_0000;
    tick();
    chk("j_take", {31'd0, is_Branch_Taken}, 32'd1);
    chk("j_bpc",  branchPC, 32'h1000_0100);
    tick();

    // ---- hazard vs branch ----
    inputIR = 32'h1022_0003; inputPC = 32'h10; rt_data = 32'd5;
    tick();
    ex_isLoad = 1'b1; ex_destReg = 5'd2; #1;
    chk("sim_ilk",  {31'd0, isDataInterLock}, 32'd1);
    chk("sim_take", {31'd0, is_Branch_Taken}, 32'd0);
    chk("sim_bpc",  branchPC, 32'h0);
    tick();
    chk("sim_hold", IR_ID, 32'h1022_0003);
    ex_isLoad = 1'b0; #1;
    chk("sim_res_take", {31'd0, is_Branch_Taken}, 32'd1);
    chk("sim_res_bpc",  branchPC, 32'h20);
    tick();

    // ---- reset mid-FLUSH ----
    reset = 1'b0; inputIR = 32'h1111_1111; inputPC = 32'h24;
    tick();
    chk("rstf_ir",    IR_ID, 32'h0);
    chk("rstf_pc",    PC_ID, 32'h0);
    chk("rstf_valid", {31'd0, id_valid}, 32'd0);

`ifdef ID_PERF_CNT_EN
    // ---- perf counters ----
    chk("cnt_rst_stall", {28'd0, stall_count}, 32'd0);
    chk("cnt_rst_flush", {28'd0, flush_count}, 32'd0);
    reset = 1'b1; inputIR = 32'h0022_1820; inputPC = 32'h100;
    tick();
    ex_isLoad = 1'b1; ex_destReg = 5'd1;
    for (int i = 0; i < 20; i++) tick();
    chk("cnt_stall_sat", {28'd0, stall_count}, 32'hF);
    ex_isLoad = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1; inputIR = 32'h1022_0003; inputPC = 32'h10;
    rs_data = 32'd7; rt_data = 32'd7;
    for (int i = 0; i < 6; i++) tick();
    chk("cnt_flush", {28'd0, flush_count}, 32'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
